// File: rtl/cdm_pipe_mult.sv
// Pipelined carry-disregard approximate multiplier with a valid/ready input and output handshake.
// Define CDM_ERRSTAT_EN to build the on-line error monitor (err_cnt / err_sum / err_max).
module cdm_pipe_mult #(
    parameter int W      = 16,
    parameter int K      = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   R,
    input  logic             stat_clr,
    output logic [31:0]      err_cnt,
    output logic [47:0]      err_sum,
    output logic [2*W-1:0]   err_max
);

    localparam int PW = 2 * W;
    localparam logic [PW-1:0] ONE      = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] LOW_MASK = (K >= PW) ? {PW{1'b1}} : ((ONE << K) - ONE);

    logic          adv;
    logic [PW-1:0] row [W];
    logic [PW-1:0] hi_sum;
    logic [PW-1:0] lo_or;
    logic [PW-1:0] exact_prod;
    logic [PW-1:0] prod_next;

    logic [STAGES-1:0] vld_reg;
    logic [PW-1:0]     prod_reg [STAGES];

    // Each row holds the partial products of A[gi], already placed in their result columns.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_row
            assign row[gi] = A[gi] ? ({{W{1'b0}}, B} << gi) : '0;
        end
    endgenerate

    // Columns below K are OR-combined, so they never carry into each other or into column K.
    always_comb begin
        hi_sum = '0;
        lo_or  = '0;
        for (int i = 0; i < W; i++) begin
            hi_sum = hi_sum + (row[i] & ~LOW_MASK);
            lo_or  = lo_or | (row[i] & LOW_MASK);
        end
    end

    assign exact_prod = {{W{1'b0}}, A} * {{W{1'b0}}, B};
    assign prod_next  = (approx_en && (K != 0)) ? (hi_sum | lo_or) : exact_prod;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_reg[STAGES-1];
    assign R         = prod_reg[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
            for (int i = 0; i < STAGES; i++) begin
                prod_reg[i] <= '0;
            end
        end else if (adv) begin
            vld_reg[0]  <= in_valid;
            prod_reg[0] <= prod_next;
            for (int i = 1; i < STAGES; i++) begin
                vld_reg[i]  <= vld_reg[i-1];
                prod_reg[i] <= prod_reg[i-1];
            end
        end
    end

`ifdef CDM_ERRSTAT_EN
    localparam int SW = (PW > 48) ? PW : 48;

    logic [W-1:0]  a_reg [STAGES];
    logic [W-1:0]  b_reg [STAGES];
    logic [PW-1:0] ref_prod;
    logic [PW-1:0] err_abs;
    logic [SW:0]   sum_wide;
    logic          xfer;

    // Operands ride alongside the product so the reference is computed at the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else if (adv) begin
            a_reg[0] <= A;
            b_reg[0] <= B;
            for (int i = 1; i < STAGES; i++) begin
                a_reg[i] <= a_reg[i-1];
                b_reg[i] <= b_reg[i-1];
            end
        end
    end

    assign ref_prod = {{W{1'b0}}, a_reg[STAGES-1]} * {{W{1'b0}}, b_reg[STAGES-1]};
    assign err_abs  = (ref_prod >= R) ? (ref_prod - R) : (R - ref_prod);
    assign sum_wide = {{(SW-48+1){1'b0}}, err_sum} + {{(SW-PW+1){1'b0}}, err_abs};
    assign xfer     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_sum <= '0;
            err_max <= '0;
        end else if (stat_clr) begin
            err_cnt <= '0;
            err_sum <= '0;
            err_max <= '0;
        end else if (xfer && (err_abs != '0)) begin
            if (err_cnt != {32{1'b1}}) begin
                err_cnt <= err_cnt + 32'd1;
            end
            if (sum_wide > {{(SW-48+1){1'b0}}, {48{1'b1}}}) begin
                err_sum <= {48{1'b1}};
            end else begin
                err_sum <= sum_wide[47:0];
            end
            if (err_abs > err_max) begin
                err_max <= err_abs;
            end
        end
    end
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign err_cnt         = '0;
    assign err_sum         = '0;
    assign err_max         = '0;
`endif

endmodule

// File: tb/tb_cdm_pipe_mult.sv
// Directed bench for cdm_pipe_mult (W=16, K=8, STAGES=2) plus a K=0 instance fed random operands.
module tb_cdm_pipe_mult;

`ifdef CDM_ERRSTAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, approx_en, out_valid, out_ready, stat_clr;
    logic [15:0] a, b;
    logic [31:0] r, err_max;
    logic [31:0] err_cnt;
    logic [47:0] err_sum;

    logic        k0_in_valid, k0_in_ready, k0_en, k0_out_valid, k0_out_ready, k0_stat_clr;
    logic [15:0] k0_a, k0_b;
    logic [31:0] k0_r, k0_err_max;
    logic [31:0] k0_err_cnt;
    logic [47:0] k0_err_sum;

    int tests_run    = 0;
    int tests_failed = 0;
    int sent, got, bad;
    logic [31:0] held;
    logic [31:0] k0_q[$];

    always #5 clk = ~clk;

    cdm_pipe_mult #(.W(16), .K(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready),
        .R(r), .stat_clr(stat_clr), .err_cnt(err_cnt), .err_sum(err_sum), .err_max(err_max)
    );

    cdm_pipe_mult #(.W(16), .K(0), .STAGES(2)) dut_k0 (
        .clk(clk), .rst_n(rst_n), .in_valid(k0_in_valid), .in_ready(k0_in_ready),
        .A(k0_a), .B(k0_b), .approx_en(k0_en), .out_valid(k0_out_valid), .out_ready(k0_out_ready),
        .R(k0_r), .stat_clr(k0_stat_clr), .err_cnt(k0_err_cnt), .err_sum(k0_err_sum), .err_max(k0_err_max)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_stats(input string tag, input logic [31:0] cnt, input logic [47:0] sum,
                               input logic [31:0] mx);
        check({tag, "_cnt"}, err_cnt, STAT ? cnt : 32'd0);
        check({tag, "_sum"}, err_sum, STAT ? sum : 48'd0);
        check({tag, "_max"}, err_max, STAT ? mx : 32'd0);
    endtask

    // One isolated transaction: checks acceptance, 2-cycle latency, result and single output beat.
    task automatic run_txn(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic en, input logic [31:0] exp_r, input logic clr_at_out);
        @(negedge clk);
        a = av; b = bv; approx_en = en; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early_valid"}, out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_r"}, r, exp_r);
        $display("[TB] txn %s A=0x%h B=0x%h approx=%0d R=0x%h", tag, av, bv, en, r);
        stat_clr = clr_at_out;
        @(negedge clk);
        stat_clr = 1'b0;
        check({tag, "_no_dup"}, out_valid, 1'b0);
    endtask

    logic [15:0] a_tab [3] = '{16'd3, 16'd5, 16'd3};
    logic [15:0] b_tab [3] = '{16'd3, 16'd1, 16'd3};
    logic [31:0] r_tab [3] = '{32'd7, 32'd5, 32'd7};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; approx_en = 1'b1; stat_clr = 1'b0;
        a = '0; b = '0;
        k0_in_valid = 1'b0; k0_out_ready = 1'b1; k0_en = 1'b0; k0_stat_clr = 1'b0;
        k0_a = '0; k0_b = '0;

        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_r", r, 32'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check_stats("rst", 32'd0, 48'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("t1_3x3_approx", 16'd3, 16'd3, 1'b1, 32'd7, 1'b0);
        check_stats("t1", 32'd1, 48'd2, 32'd2);
        run_txn("t2_3x3_exact", 16'd3, 16'd3, 1'b0, 32'd9, 1'b0);
        check_stats("t2", 32'd1, 48'd2, 32'd2);
        run_txn("t3_300x3", 16'h0300, 16'd3, 1'b1, 32'h900, 1'b0);
        run_txn("t3_ffffx1", 16'hFFFF, 16'd1, 1'b1, 32'hFFFF, 1'b0);
        run_txn("t3_100x100", 16'h0100, 16'h0100, 1'b1, 32'h10000, 1'b0);
        check_stats("t3", 32'd1, 48'd2, 32'd2);
        // 0xFF*0xFF: low byte ORs to 0xFF, high columns sum to 0xF700; exact 0xFE01, error 0x602.
        run_txn("t3_ffxff", 16'h00FF, 16'h00FF, 1'b1, 32'hF7FF, 1'b0);
        check_stats("t3b", 32'd2, 48'd1540, 32'h602);

        // Back-to-back stream with a 3-cycle output stall.
        sent = 0; got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 4);
            approx_en = 1'b1;
            in_valid = (sent < 3);
            if (sent < 3) begin
                a = a_tab[sent]; b = b_tab[sent];
            end
            #1;
            if (c == 2) check("s_first_valid", out_valid, 1'b1);
            if (out_valid && !out_ready) begin
                check("s_stall_in_ready", in_ready, 1'b0);
                if (c == 2) held = r;
                else check("s_hold_r", r, held);
            end
            if (out_valid && out_ready) begin
                check("s_r", r, r_tab[got]);
                $display("[TB] txn stream#%0d R=0x%h", got, r);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("s_count", got, 3);
        check("s_no_dup", out_valid, 1'b0);
        check_stats("s", 32'd4, 48'd1544, 32'h602);

        // Reset with two transactions in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h10; b = 16'h10;
        @(negedge clk);
        a = 16'h20; b = 16'h20;
        @(negedge clk);
        in_valid = 1'b0;
        check("rm_pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rm_out_valid", out_valid, 1'b0);
        check("rm_r", r, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("rm_no_stale", bad, 0);
        check_stats("rm", 32'd0, 48'd0, 32'd0);
        $display("[TB] txn reset-flush done");

        // K=0 instance: every product must be exact regardless of approx_en.
        sent = 0; got = 0;
        for (int c = 0; c < 3000 && got < 1000; c++) begin
            @(negedge clk);
            k0_in_valid = (sent < 1000);
            k0_a = 16'($urandom_range(0, 65535));
            k0_b = 16'($urandom_range(0, 65535));
            k0_en = 1'($urandom_range(0, 1));
            #1;
            if (k0_out_valid && k0_out_ready) begin
                if (k0_q.size() == 0) begin
                    check("k0_spurious", 1'b1, 1'b0);
                end else begin
                    check("k0_r", k0_r, k0_q.pop_front());
                    $display("[TB] txn k0#%0d R=0x%h", got, k0_r);
                end
                got++;
            end
            if (k0_in_valid && k0_in_ready) begin
                k0_q.push_back(32'(k0_a) * 32'(k0_b));
                sent++;
            end
        end
        k0_in_valid = 1'b0;
        check("k0_count", got, 1000);
        check("k0_err_cnt", k0_err_cnt, 32'd0);

        // Clear coinciding with an erroneous transfer leaves all counters at zero.
        run_txn("c_seed", 16'd3, 16'd3, 1'b1, 32'd7, 1'b0);
        check_stats("c_seed", 32'd1, 48'd2, 32'd2);
        run_txn("c_clr", 16'd3, 16'd3, 1'b1, 32'd7, 1'b1);
        check_stats("c_clr", 32'd0, 48'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
